// File: rtl/regfile_pkg.sv
// Shared types and helpers for the 2-read / 1-write register file.
//   clr_state_t : clear-sweep FSM state encoding
//   be_merge    : byte-lane merge of an old word with new data under byte enables,
//                 used by both the write path and the read-port bypass so the two
//                 can never disagree about the post-write value.
// be_merge works on a fixed wide word; callers zero-extend their operands and
// truncate the result back to WIDTH (WIDTH must not exceed MERGE_W).
package regfile_pkg;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_t;

  localparam int MERGE_W  = 256;
  localparam int MERGE_BE = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]  old_v,
    input logic [MERGE_W-1:0]  new_v,
    input logic [MERGE_BE-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_v;
    for (int i = 0; i < MERGE_BE; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port of the register file.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   rd_en_i, rd_addr_i: read request and address
//   mem_i             : current storage contents (pre-edge values)
//   wr_accept_i, wr_addr_i, wr_data_i, wr_be_i : the write accepted this edge, for bypass
//   rd_data_o         : registered read data (holds when no read)
//   rd_valid_o        : high for the cycle after an edge that sampled rd_en_i=1
// Read handshake: rd_valid_o is a pure one-cycle qualifier of rd_data_o; there is
// no back-pressure, a request sampled at an edge always completes at that edge.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter bit ZERO_REG = 1'b0,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int BE_W    = WIDTH / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [WIDTH-1:0]  mem_i [DEPTH],
  input  logic              wr_accept_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [BE_W-1:0]   wr_be_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              rd_valid_o
);

  logic             in_range;
  logic             zero_hit;
  logic             bypass;
  logic [WIDTH-1:0] old_word;
  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  assign in_range = ({1'b0, rd_addr_i} < (ADDR_W+1)'(DEPTH));
  assign zero_hit = ZERO_REG && (rd_addr_i == '0);
  // wr_accept_i already excludes out-of-range and zero-register writes and is
  // low during a clear sweep, so a plain address match is enough here.
  assign bypass   = wr_accept_i && (wr_addr_i == rd_addr_i);
  assign old_word = in_range ? mem_i[rd_addr_i] : '0;

  always_comb begin
    rd_data_d = old_word;
    if (!in_range || zero_hit) begin
      rd_data_d = '0;
    end else if (bypass) begin
      rd_data_d = WIDTH'(be_merge(MERGE_W'(old_word), MERGE_W'(wr_data_i),
                                  MERGE_BE'(wr_be_i)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file: 1 byte-enabled write port, 2 independent registered read ports
// with write-first bypass, and a sequenced clear engine.
//   CLK, RST                   : clock, synchronous active-high reset
//   WrEn/WrAddr/WrData/WrByteEn: write port
//   RdEnA/RdAddrA -> RdDataA/RdValidA, same for port B: read ports, latency 1
//   ClrReq                     : start a clear sweep (ignored while busy)
//   ClrBusy                    : sweep in progress (DEPTH cycles)
//   ClrStateDbg                : current clear FSM state, for observation
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter bit ZERO_REG = 1'b0,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int BE_W    = WIDTH / 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic [BE_W-1:0]   WrByteEn,
  input  logic              RdEnA,
  input  logic [ADDR_W-1:0] RdAddrA,
  output logic [WIDTH-1:0]  RdDataA,
  output logic              RdValidA,
  input  logic              RdEnB,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [WIDTH-1:0]  RdDataB,
  output logic              RdValidB,
  input  logic              ClrReq,
  output logic              ClrBusy,
  output logic              ClrStateDbg
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  clr_state_t        state_q;
  logic [ADDR_W-1:0] idx_q;

  logic              wr_in_range;
  logic              wr_accept;
  logic [WIDTH-1:0]  wr_old;
  logic [WIDTH-1:0]  wr_merged;

  assign wr_in_range = ({1'b0, WrAddr} < (ADDR_W+1)'(DEPTH));
  // A write is only accepted outside a sweep; ZERO_REG drops writes to entry 0.
  assign wr_accept   = WrEn && (state_q == CLR_IDLE) && wr_in_range &&
                       !(ZERO_REG && (WrAddr == '0));
  assign wr_old      = wr_in_range ? mem_q[WrAddr] : '0;
  assign wr_merged   = WIDTH'(be_merge(MERGE_W'(wr_old), MERGE_W'(WrData),
                                       MERGE_BE'(WrByteEn)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q <= CLR_IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        CLR_IDLE: begin
          // A write in the same cycle as ClrReq still lands; the sweep then clears it.
          if (wr_accept) mem_q[WrAddr] <= wr_merged;
          if (ClrReq) begin
            state_q <= CLR_SWEEP;
            idx_q   <= '0;
          end
        end
        CLR_SWEEP: begin
          mem_q[idx_q] <= '0;
          if (idx_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= CLR_IDLE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= CLR_IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign ClrBusy     = (state_q == CLR_SWEEP);
  assign ClrStateDbg = state_q;

  regfile_rd_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)
  ) u_rd_a (
    .clk_i(CLK), .rst_i(RST),
    .rd_en_i(RdEnA), .rd_addr_i(RdAddrA), .mem_i(mem_q),
    .wr_accept_i(wr_accept), .wr_addr_i(WrAddr), .wr_data_i(WrData), .wr_be_i(WrByteEn),
    .rd_data_o(RdDataA), .rd_valid_o(RdValidA)
  );

  regfile_rd_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)
  ) u_rd_b (
    .clk_i(CLK), .rst_i(RST),
    .rd_en_i(RdEnB), .rd_addr_i(RdAddrB), .mem_i(mem_q),
    .wr_accept_i(wr_accept), .wr_addr_i(WrAddr), .wr_data_i(WrData), .wr_be_i(WrByteEn),
    .rd_data_o(RdDataB), .rd_valid_o(RdValidB)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: a default instance (DEPTH=8, ZERO_REG=0) and a
// ZERO_REG=1, DEPTH=6 instance sharing the same input stimulus.
module tb_regfile_2r1w;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_en_a, rd_en_b;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic        clr_req;

  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, clr_busy, clr_state;
  logic [15:0] z_data_a, z_data_b;
  logic        z_valid_a, z_valid_b, z_busy, z_state;

  regfile_2r1w #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b0)) dut (
    .CLK(clk), .RST(rst),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .WrByteEn(wr_be),
    .RdEnA(rd_en_a), .RdAddrA(rd_addr_a), .RdDataA(rd_data_a), .RdValidA(rd_valid_a),
    .RdEnB(rd_en_b), .RdAddrB(rd_addr_b), .RdDataB(rd_data_b), .RdValidB(rd_valid_b),
    .ClrReq(clr_req), .ClrBusy(clr_busy), .ClrStateDbg(clr_state)
  );

  regfile_2r1w #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1'b1)) dut_z (
    .CLK(clk), .RST(rst),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .WrByteEn(wr_be),
    .RdEnA(rd_en_a), .RdAddrA(rd_addr_a), .RdDataA(z_data_a), .RdValidA(z_valid_a),
    .RdEnB(rd_en_b), .RdAddrB(rd_addr_b), .RdDataB(z_data_b), .RdValidB(z_valid_b),
    .ClrReq(clr_req), .ClrBusy(z_busy), .ClrStateDbg(z_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [1:0] be, input logic rea, input logic [2:0] raa,
                        input logic reb, input logic [2:0] rab, input logic clr);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en_a = rea; rd_addr_a = raa; rd_en_b = reb; rd_addr_b = rab;
    clr_req = clr;
  endtask

  task automatic idle();
    set_in(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  // Advance one edge and land 1 time unit after it for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    set_in(1'b1, a, d, be, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick();
  endtask

  task automatic read_a(input logic [2:0] a);
    set_in(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, a, 1'b0, 3'd0, 1'b0);
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        rea;
    logic [2:0]  raa;
    logic        reb;
    logic [2:0]  rab;
    logic        exp_va;
    logic [15:0] exp_a;
    logic        exp_vb;
    logic [15:0] exp_b;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                              input logic [1:0] be, input logic rea, input logic [2:0] raa,
                              input logic reb, input logic [2:0] rab, input logic eva,
                              input logic [15:0] ea, input logic evb, input logic [15:0] eb);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.be = be;
    v.rea = rea; v.raa = raa; v.reb = reb; v.rab = rab;
    v.exp_va = eva; v.exp_a = ea; v.exp_vb = evb; v.exp_b = eb;
    return v;
  endfunction

  vec_t        vecs [11];
  logic [15:0] z_model [6];
  int          busy_cnt;
  int          guard;

  initial begin
    //        we  wa    wd        be     rea raa  reb rab  va  expA      vb  expB
    vecs[0]  = mk(0, 3'd0, 16'h0000, 2'b00, 1, 3'd1, 1, 3'd7, 1, 16'h0000, 1, 16'h0000);
    vecs[1]  = mk(1, 3'd3, 16'h002B, 2'b11, 0, 3'd0, 0, 3'd0, 0, 16'h0000, 0, 16'h0000);
    vecs[2]  = mk(1, 3'd7, 16'h0001, 2'b11, 1, 3'd3, 0, 3'd0, 1, 16'h002B, 0, 16'h0000);
    vecs[3]  = mk(0, 3'd0, 16'h0000, 2'b00, 1, 3'd3, 1, 3'd7, 1, 16'h002B, 1, 16'h0001);
    vecs[4]  = mk(1, 3'd1, 16'h1234, 2'b11, 0, 3'd0, 0, 3'd0, 0, 16'h002B, 0, 16'h0001);
    vecs[5]  = mk(1, 3'd1, 16'hABCD, 2'b01, 1, 3'd1, 0, 3'd0, 1, 16'h12CD, 0, 16'h0001);
    vecs[6]  = mk(0, 3'd0, 16'h0000, 2'b00, 1, 3'd1, 1, 3'd1, 1, 16'h12CD, 1, 16'h12CD);
    vecs[7]  = mk(1, 3'd5, 16'hBEEF, 2'b10, 0, 3'd0, 1, 3'd5, 0, 16'h12CD, 1, 16'hBE00);
    vecs[8]  = mk(1, 3'd5, 16'h1111, 2'b00, 1, 3'd5, 0, 3'd0, 1, 16'hBE00, 0, 16'hBE00);
    vecs[9]  = mk(1, 3'd2, 16'h4242, 2'b11, 1, 3'd2, 1, 3'd2, 1, 16'h4242, 1, 16'h4242);
    vecs[10] = mk(0, 3'd0, 16'h0000, 2'b00, 1, 3'd7, 1, 3'd3, 1, 16'h0001, 1, 16'h002B);

    // Contents of the DEPTH=6, ZERO_REG=1 instance after the table above
    // (write to addr 7 is out of range there and dropped).
    z_model[0] = 16'h0000; z_model[1] = 16'h12CD; z_model[2] = 16'h4242;
    z_model[3] = 16'h002B; z_model[4] = 16'h0000; z_model[5] = 16'hBE00;

    // ---- reset ----
    idle();
    rst = 1'b1;
    tick();
    check("rst_data_a",  rd_data_a, 16'h0);
    check("rst_data_b",  rd_data_b, 16'h0);
    check("rst_valid_a", {15'h0, rd_valid_a}, 16'h0);
    check("rst_valid_b", {15'h0, rd_valid_b}, 16'h0);
    check("rst_busy",    {15'h0, clr_busy}, 16'h0);
    check("rst_z_valid", {15'h0, z_valid_a}, 16'h0);
    rst = 1'b0;

    // ---- table-driven reads/writes/bypass ----
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be,
             vecs[i].rea, vecs[i].raa, vecs[i].reb, vecs[i].rab, 1'b0);
      tick();
      check($sformatf("vec%0d_valid_a", i), {15'h0, rd_valid_a}, {15'h0, vecs[i].exp_va});
      check($sformatf("vec%0d_data_a", i),  rd_data_a, vecs[i].exp_a);
      check($sformatf("vec%0d_valid_b", i), {15'h0, rd_valid_b}, {15'h0, vecs[i].exp_vb});
      check($sformatf("vec%0d_data_b", i),  rd_data_b, vecs[i].exp_b);
    end

    // ---- zero register and out-of-range address (dut_z) ----
    set_in(1'b1, 3'd0, 16'hFFFF, 2'b11, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    tick();
    check("z_wr0_bypass", z_data_a, 16'h0000);
    check("wr0_bypass",   rd_data_a, 16'hFFFF);
    read_a(3'd0);
    check("z_rd0",        z_data_a, 16'h0000);
    check("z_rd0_valid",  {15'h0, z_valid_a}, 16'h1);
    check("rd0",          rd_data_a, 16'hFFFF);
    set_in(1'b1, 3'd6, 16'h5555, 2'b11, 1'b0, 3'd0, 1'b1, 3'd6, 1'b0);
    tick();
    check("z_oor_rd6",       z_data_b, 16'h0000);
    check("z_oor_rd6_valid", {15'h0, z_valid_b}, 16'h1);
    check("rd6_bypass",      rd_data_b, 16'h5555);
    read_a(3'd7);
    check("z_oor_rd7", z_data_a, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      read_a(3'(i));
      check($sformatf("z_entry%0d", i), z_data_a, z_model[i]);
    end

    // ---- clear sweep: exact busy length, lost write, reads during sweep ----
    for (int i = 0; i < 8; i++) write(3'(i), 16'hAAAA, 2'b11);
    set_in(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    tick();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("sweep%0d_busy", k), {15'h0, clr_busy}, 16'h1);
      if (k >= 1) check($sformatf("sweep%0d_rd_a", k), rd_data_a, 16'hAAAA);
      if (k >= 2) check($sformatf("sweep%0d_rd_b", k), rd_data_b, 16'h0000);
      // A reads the entry cleared at the coming edge (old value expected);
      // B reads the entry cleared one edge earlier (zero expected).
      set_in(k == 3, 3'd1, 16'h7777, 2'b11, 1'b1, 3'(k), k >= 1, 3'(k - 1), k == 5);
      tick();
    end
    check("sweep_end_busy", {15'h0, clr_busy}, 16'h0);
    check("sweep_end_rd_a", rd_data_a, 16'hAAAA);
    check("sweep_end_rd_b", rd_data_b, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      read_a(3'(i));
      check($sformatf("after_clr_entry%0d", i), rd_data_a, 16'h0000);
    end

    // ---- reset mid-sweep, then a fresh full sweep ----
    for (int i = 0; i < 8; i++) write(3'(i), 16'h5A5A, 2'b11);
    set_in(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    tick();
    idle();
    check("abort_busy0", {15'h0, clr_busy}, 16'h1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy_after_rst", {15'h0, clr_busy}, 16'h0);
    check("abort_state_after_rst", {15'h0, clr_state}, 16'h0);
    for (int i = 0; i < 8; i++) begin
      read_a(3'(i));
      check($sformatf("after_rst_entry%0d", i), rd_data_a, 16'h0000);
    end
    set_in(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    tick();
    idle();
    busy_cnt = 0;
    guard    = 0;
    while (clr_busy && guard < 20) begin
      busy_cnt++;
      guard++;
      tick();
    end
    check("resweep_busy_cycles", 16'(busy_cnt), 16'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
